// File: rtl/zpu_sd_bridge.sv
// ZPU-to-HPS SD block bridge: request handshake FSM, 512-byte sector buffer port and mount status.
// Define ZPU_SD_WRITE_EN to include the block write request and buffer write path.
module zpu_sd_bridge #(
    parameter logic [23:0] ACK_TIMEOUT = 24'd0,
    parameter logic [2:0]  FILENO      = 3'd0
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] ZPU_OUT2,
    input  logic [31:0] ZPU_OUT3,
    input  logic [15:0] ZPU_RD,
    input  logic [15:0] ZPU_WR,
    output logic [7:0]  ZPU_IN2,
    output logic [31:0] ZPU_IN3,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic        img_mounted,
    input  logic [63:0] img_size,
    input  logic [7:0]  ioctl_index,
    output logic [8:0]  buf_addr,
    output logic [7:0]  buf_dout,
    output logic        buf_wr,
    input  logic [7:0]  buf_q
);

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned TMO_W  = 24;
    localparam logic [TMO_W-1:0] TMO_LAST = ACK_TIMEOUT - TMO_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               sd_rd_q, sd_rd_d;
    logic               sd_wr_q, sd_wr_d;
    logic               io_done_q, io_done_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [31:0]        lba_q, lba_d;
    logic               buf_wr_q, buf_wr_d;
    logic [ADDR_W-1:0]  buf_addr_q, buf_addr_d;
    logic               blk_rd_q;
    logic               dwr_d1_q, dwr_d2_q;
    logic               drd_d1_q, drd_d2_q;
    logic               mnt_q;
    logic               mounted_q, mounted_d;
    logic [2:0]         fileno_q, fileno_d;
    logic [1:0]         filetype_q, filetype_d;
    logic               readonly_q, readonly_d;
    logic [31:0]        filesize_q, filesize_d;

    logic lba_sel, io_wr;
    logic rd_rise, wr_rise, dwr_evt, drd_fall, mnt_rise, tmo_hit;
    logic unused_ok;

    assign lba_sel  = ZPU_OUT2[0];
    assign io_wr    = ZPU_WR[5];
    assign rd_rise  = ZPU_OUT2[1] & ~blk_rd_q;
    assign dwr_evt  = dwr_d1_q & ~dwr_d2_q;
    assign drd_fall = ~drd_d1_q & drd_d2_q;
    assign mnt_rise = img_mounted & ~mnt_q;
    assign tmo_hit  = (ACK_TIMEOUT != TMO_W'(0)) && (tmo_q == TMO_LAST);

`ifdef ZPU_SD_WRITE_EN
    logic blk_wr_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            blk_wr_q <= 1'b0;
        end else begin
            blk_wr_q <= ZPU_OUT2[2];
        end
    end

    assign wr_rise  = ZPU_OUT2[2] & ~blk_wr_q;
    assign buf_wr_d = dwr_evt & ~lba_sel;
    assign unused_ok = ^{ZPU_OUT2[31:3], ZPU_RD[15:3], ZPU_RD[1:0], ZPU_WR[15:7],
                         ZPU_WR[4:0], img_size[63:32], ioctl_index[5:0]};
`else
    assign wr_rise  = 1'b0;
    assign buf_wr_d = 1'b0;
    assign unused_ok = ^{ZPU_OUT2[31:2], ZPU_RD[15:3], ZPU_RD[1:0], ZPU_WR[15:7],
                         ZPU_WR[4:0], img_size[63:32], ioctl_index[5:0]};
`endif

    // Request handshake: IDLE -> REQ (wait ack or timeout) -> XFER (wait ack fall) -> IDLE
    always_comb begin
        state_d   = state_q;
        sd_rd_d   = sd_rd_q;
        sd_wr_d   = sd_wr_q;
        io_done_d = io_done_q;
        tmo_d     = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_rise) begin
                    sd_rd_d   = 1'b1;
                    io_done_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = ST_REQ;
                end else if (wr_rise) begin
                    sd_wr_d   = 1'b1;
                    io_done_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (sd_ack) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    state_d = ST_XFER;
                end else if (tmo_hit) begin
                    sd_rd_d   = 1'b0;
                    sd_wr_d   = 1'b0;
                    io_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_XFER: begin
                if (!sd_ack) begin
                    io_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                sd_rd_d   = 1'b0;
                sd_wr_d   = 1'b0;
                io_done_d = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Buffer address, LBA capture and mount status
    always_comb begin
        lba_d      = lba_q;
        buf_addr_d = buf_addr_q;
        mounted_d  = mounted_q;
        fileno_d   = fileno_q;
        filetype_d = filetype_q;
        readonly_d = readonly_q;
        filesize_d = filesize_q;

        if (dwr_evt && lba_sel) begin
            lba_d = ZPU_OUT3;
        end

        // io_wr clear wins over any pending increment; the 9-bit add wraps 511 -> 0
        if (io_wr) begin
            buf_addr_d = '0;
        end else begin
            buf_addr_d = buf_addr_q + ADDR_W'(buf_wr_q) + ADDR_W'(drd_fall);
        end

        if (mnt_rise) begin
            mounted_d  = ~mounted_q;
            fileno_d   = FILENO;
            filetype_d = ioctl_index[7:6];
            readonly_d = 1'b1;
            filesize_d = img_size[31:0];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            sd_rd_q    <= 1'b0;
            sd_wr_q    <= 1'b0;
            io_done_q  <= 1'b1;
            tmo_q      <= '0;
            lba_q      <= '0;
            buf_wr_q   <= 1'b0;
            buf_addr_q <= '0;
            blk_rd_q   <= 1'b0;
            dwr_d1_q   <= 1'b0;
            dwr_d2_q   <= 1'b0;
            drd_d1_q   <= 1'b0;
            drd_d2_q   <= 1'b0;
            mnt_q      <= 1'b0;
            mounted_q  <= 1'b0;
            fileno_q   <= '0;
            filetype_q <= '0;
            readonly_q <= 1'b0;
            filesize_q <= '0;
        end else begin
            state_q    <= state_d;
            sd_rd_q    <= sd_rd_d;
            sd_wr_q    <= sd_wr_d;
            io_done_q  <= io_done_d;
            tmo_q      <= tmo_d;
            lba_q      <= lba_d;
            buf_wr_q   <= buf_wr_d;
            buf_addr_q <= buf_addr_d;
            blk_rd_q   <= ZPU_OUT2[1];
            dwr_d1_q   <= ZPU_WR[6];
            dwr_d2_q   <= dwr_d1_q;
            drd_d1_q   <= ZPU_RD[2];
            drd_d2_q   <= drd_d1_q;
            mnt_q      <= img_mounted;
            mounted_q  <= mounted_d;
            fileno_q   <= fileno_d;
            filetype_q <= filetype_d;
            readonly_q <= readonly_d;
            filesize_q <= filesize_d;
        end
    end

    assign sd_rd    = sd_rd_q;
    assign sd_wr    = sd_wr_q;
    assign sd_lba   = lba_q;
    assign buf_wr   = buf_wr_q;
    assign buf_addr = buf_addr_q;
    assign buf_dout = ZPU_OUT3[7:0];
    assign ZPU_IN2  = {readonly_q, filetype_q, fileno_q, mounted_q, io_done_q};
    assign ZPU_IN3  = lba_sel ? filesize_q : {24'h0, buf_q};

endmodule

// File: tb/tb_zpu_sd_bridge.sv
// Directed bench for zpu_sd_bridge; expectations follow the ZPU_SD_WRITE_EN build setting.
module tb_zpu_sd_bridge;

`ifdef ZPU_SD_WRITE_EN
    localparam bit WE = 1'b1;
`else
    localparam bit WE = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [31:0] ZPU_OUT2, ZPU_OUT3;
    logic [15:0] ZPU_RD, ZPU_WR;
    logic [7:0]  ZPU_IN2;
    logic [31:0] ZPU_IN3;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack, img_mounted;
    logic [63:0] img_size;
    logic [7:0]  ioctl_index;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_dout;
    logic        buf_wr;
    logic [7:0]  buf_q;

    int nchecks = 0;
    int nerr    = 0;

    zpu_sd_bridge #(.ACK_TIMEOUT(24'd16), .FILENO(3'd0)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .ZPU_OUT2(ZPU_OUT2), .ZPU_OUT3(ZPU_OUT3), .ZPU_RD(ZPU_RD), .ZPU_WR(ZPU_WR),
        .ZPU_IN2(ZPU_IN2), .ZPU_IN3(ZPU_IN3),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .img_mounted(img_mounted), .img_size(img_size), .ioctl_index(ioctl_index),
        .buf_addr(buf_addr), .buf_dout(buf_dout), .buf_wr(buf_wr), .buf_q(buf_q)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // data_rd pulse; buf_addr steps two edges after the strobe drops
    task automatic rd_pulse();
        ZPU_RD = 16'h0004;
        tick(1);
        ZPU_RD = 16'h0000;
        tick(2);
    endtask

    initial begin
        RESET_N = 1'b0; ZPU_OUT2 = '0; ZPU_OUT3 = '0; ZPU_RD = '0; ZPU_WR = '0;
        sd_ack = 1'b0; img_mounted = 1'b0; img_size = '0; ioctl_index = '0; buf_q = 8'h5A;
        #12;
        chk("rst_sd_rd",    64'(sd_rd),    64'h0);
        chk("rst_sd_wr",    64'(sd_wr),    64'h0);
        chk("rst_buf_wr",   64'(buf_wr),   64'h0);
        chk("rst_buf_addr", 64'(buf_addr), 64'h0);
        chk("rst_sd_lba",   64'(sd_lba),   64'h0);
        chk("rst_in2",      64'(ZPU_IN2),  64'h01);
        chk("rst_in3_buf",  64'(ZPU_IN3),  64'h5A);
        tick(1);
        RESET_N = 1'b1;
        tick(2);

        // LBA load
        ZPU_OUT2 = 32'h1; ZPU_OUT3 = 32'h0000_1234; ZPU_WR = 16'h0040;
        tick(1);
        chk("lba_one_edge", 64'(sd_lba), 64'h0);
        tick(1);
        chk("lba_loaded",  64'(sd_lba), 64'h1234);
        chk("lba_no_bufwr", 64'(buf_wr), 64'h0);
        chk("in3_fsize0",  64'(ZPU_IN3), 64'h0);
        ZPU_WR = 16'h0; ZPU_OUT2 = 32'h0;
        tick(3);

        // data_rd falls advance buf_addr; io_wr clears and overrides
        rd_pulse();
        chk("rd_addr1", 64'(buf_addr), 64'h1);
        rd_pulse();
        chk("rd_addr2", 64'(buf_addr), 64'h2);
        ZPU_WR = 16'h0020;
        tick(1);
        chk("iowr_clear", 64'(buf_addr), 64'h0);
        ZPU_WR = 16'h0;
        ZPU_RD = 16'h0004; tick(1); ZPU_RD = 16'h0; tick(1);
        ZPU_WR = 16'h0020; tick(1);
        chk("iowr_override", 64'(buf_addr), 64'h0);
        ZPU_WR = 16'h0;
        tick(1);
        chk("iowr_after", 64'(buf_addr), 64'h0);

        // Buffer writes AA, BB, CC
        begin
            logic [7:0] bytes [3];
            bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC;
            for (int i = 0; i < 3; i++) begin
                ZPU_OUT3 = {24'h0, bytes[i]}; ZPU_WR = 16'h0040;
                tick(1);
                chk("bw_pre", 64'(buf_wr), 64'h0);
                tick(1);
                chk("bw_pulse", 64'(buf_wr), WE ? 64'h1 : 64'h0);
                chk("bw_addr", 64'(buf_addr), WE ? 64'(i) : 64'h0);
                chk("bw_dout", 64'(buf_dout), 64'(bytes[i]));
                ZPU_WR = 16'h0;
                tick(1);
                chk("bw_single", 64'(buf_wr), 64'h0);
                tick(1);
            end
        end
        chk("bw_addr_end", 64'(buf_addr), WE ? 64'h3 : 64'h0);
        chk("bw_lba_kept", 64'(sd_lba), 64'h1234);

        // Wrap 511 -> 0
        ZPU_WR = 16'h0020; tick(1); ZPU_WR = 16'h0;
        for (int i = 0; i < 511; i++) rd_pulse();
        chk("addr_511", 64'(buf_addr), 64'h1FF);
        rd_pulse();
        chk("addr_wrap", 64'(buf_addr), 64'h0);

        // Read request with mount during REQ
        buf_q = 8'hC3;
        tick(1);
        chk("in3_bufq", 64'(ZPU_IN3), 64'hC3);
        ZPU_OUT2 = 32'h2;
        tick(1);
        chk("rq_sd_rd", 64'(sd_rd), 64'h1);
        chk("rq_iodone", 64'(ZPU_IN2[0]), 64'h0);
        img_size = 64'h2000; ioctl_index = 8'h40; img_mounted = 1'b1;
        tick(1);
        chk("mnt_in2", 64'(ZPU_IN2), 64'hA2);
        ZPU_OUT2 = 32'h7; img_mounted = 1'b0;
        tick(1);
        chk("mnt_in3", 64'(ZPU_IN3), 64'h2000);
        chk("rq_wr_ignored", 64'(sd_wr), 64'h0);
        sd_ack = 1'b1;
        tick(1);
        chk("ack_clr_rd", 64'(sd_rd), 64'h0);
        chk("ack_busy", 64'(ZPU_IN2[0]), 64'h0);
        tick(9);
        chk("xfer_busy", 64'(ZPU_IN2[0]), 64'h0);
        sd_ack = 1'b0;
        tick(1);
        chk("xfer_done_in2", 64'(ZPU_IN2), 64'hA3);
        chk("xfer_no_wr", 64'(sd_wr), 64'h0);
        ZPU_OUT2 = 32'h0;
        tick(2);

        // Timeout
        ZPU_OUT2 = 32'h2;
        tick(1);
        chk("to_start", 64'(sd_rd), 64'h1);
        tick(15);
        chk("to_held", 64'(sd_rd), 64'h1);
        chk("to_busy", 64'(ZPU_IN2[0]), 64'h0);
        tick(1);
        chk("to_drop", 64'(sd_rd), 64'h0);
        chk("to_done", 64'(ZPU_IN2[0]), 64'h1);
        ZPU_OUT2 = 32'h0;
        tick(2);

        // Simultaneous rd/wr rise: read wins
        ZPU_OUT2 = 32'h6;
        tick(1);
        chk("col_rd", 64'(sd_rd), 64'h1);
        chk("col_wr", 64'(sd_wr), 64'h0);
        sd_ack = 1'b1; tick(1); sd_ack = 1'b0; tick(1);
        chk("col_done", 64'(ZPU_IN2[0]), 64'h1);
        ZPU_OUT2 = 32'h0;
        tick(2);

        // Write request
        ZPU_OUT2 = 32'h4;
        tick(1);
        chk("wr_req", 64'(sd_wr), WE ? 64'h1 : 64'h0);
        chk("wr_busy", 64'(ZPU_IN2[0]), WE ? 64'h0 : 64'h1);
        sd_ack = 1'b1;
        tick(1);
        chk("wr_ack", 64'(sd_wr), 64'h0);
        chk("wr_xfer", 64'(ZPU_IN2[0]), WE ? 64'h0 : 64'h1);
        sd_ack = 1'b0;
        tick(1);
        chk("wr_done", 64'(ZPU_IN2[0]), 64'h1);
        ZPU_OUT2 = 32'h0;
        tick(2);

        // Reset during REQ
        ZPU_OUT2 = 32'h2;
        tick(1);
        chk("rr_req", 64'(sd_rd), 64'h1);
        #2 RESET_N = 1'b0;
        #1;
        chk("rr_async_rd", 64'(sd_rd), 64'h0);
        chk("rr_in2", 64'(ZPU_IN2), 64'h01);
        chk("rr_lba", 64'(sd_lba), 64'h0);
        sd_ack = 1'b1; ZPU_OUT2 = 32'h0;
        tick(2);
        RESET_N = 1'b1;
        tick(1);
        sd_ack = 1'b0;
        tick(1);
        chk("rr_ack_fall_rd", 64'(sd_rd), 64'h0);
        chk("rr_ack_fall_in2", 64'(ZPU_IN2), 64'h01);
        ZPU_OUT2 = 32'h2;
        tick(1);
        chk("rr_new_req", 64'(sd_rd), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/zpu_sd_bridge.md
ZPU_SD_BRIDGE -- requirements
Module: zpu_sd_bridge

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 24'd0, CLK cycles to wait for sd_ack after a request is raised before aborting; 0 disables the timeout.
REQ-002 SHALL have parameter FILENO, default 3'd0, slot number reported on mount.
REQ-003 SHALL have port CLK  in  1  system clock; all logic runs on its rising edge.
REQ-004 SHALL have port RESET_N  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ZPU_OUT2  in  32  control: [0] lba_sel, [1] block_rd, [2] block_wr.
REQ-006 SHALL have port ZPU_OUT3  in  32  data from the ZPU; [7:0] is the buffer byte.
REQ-007 SHALL have port ZPU_RD  in  16  read strobes: [2] data_rd.
REQ-008 SHALL have port ZPU_WR  in  16  write strobes: [5] io_wr, [6] data_wr.
REQ-009 SHALL have port ZPU_IN2  out  8  status: [0] io_done, [1] mounted, [4:2] fileno, [6:5] filetype, [7] readonly.
REQ-010 SHALL have port ZPU_IN3  out  32  equal to filesize when lba_sel=1, else {24'h0, buf_q}.
REQ-011 SHALL have port sd_lba  out  32  block address sent to the HPS.
REQ-012 SHALL have port sd_rd  out  1  block read request, held until acknowledged.
REQ-013 SHALL have port sd_wr  out  1  block write request, held until acknowledged.
REQ-014 SHALL have port sd_ack  in  1  HPS transfer acknowledge, high for the whole transfer.
REQ-015 SHALL have port img_mounted  in  1  image mount pulse or level.
REQ-016 SHALL have port img_size  in  64  mounted image size in bytes.
REQ-017 SHALL have port ioctl_index  in  8  file index; [7:6] gives the filetype.
REQ-018 SHALL have port buf_addr  out  9  port-B address into the 512-byte sector dpram.
REQ-019 SHALL have port buf_dout  out  8  port-B write data, equal to ZPU_OUT3[7:0].
REQ-020 SHALL have port buf_wr  out  1  port-B write enable, single-cycle pulse.
REQ-021 SHALL have port buf_q  in  8  port-B read data.

Function
REQ-022 SHALL run a state machine with states IDLE, REQ (sd_rd or sd_wr high), XFER (sd_ack high) and IDLE again; io_done SHALL be 1 only in IDLE.
REQ-023 SHALL, in IDLE, on a rising edge of block_rd set sd_rd=1 and io_done=0 on the next edge and enter REQ.
REQ-024 SHALL, in IDLE, on a rising edge of block_wr set sd_wr=1 and io_done=0 and enter REQ.
REQ-025 SHALL give block_rd priority when block_rd and block_wr rise in the same cycle, and drop the write.
REQ-026 SHALL ignore block_rd and block_wr edges while in REQ or XFER.
REQ-027 SHALL, on the first cycle sd_ack=1, clear sd_rd and sd_wr and enter XFER.
REQ-028 SHALL, on the falling edge of sd_ack, set io_done=1 and return to IDLE.
REQ-029 SHALL, when ACK_TIMEOUT≠0 and REQ has lasted ACK_TIMEOUT cycles without sd_ack, clear sd_rd and sd_wr, set io_done=1 and return to IDLE.
REQ-030 SHALL detect the data_wr rise through a two-stage register pipeline (d1, d2) and act when d1=1 and d2=0, i.e. on the second edge after the rise.
REQ-031 SHALL, on that data_wr event, load sd_lba from ZPU_OUT3 when lba_sel=1, else pulse buf_wr for one cycle.
REQ-032 SHALL increment buf_addr by 1 on the cycle after each buf_wr pulse.
REQ-033 SHALL increment buf_addr by 1 on each falling edge of data_rd, detected one cycle late.
REQ-034 SHALL clear buf_addr to 0 whenever io_wr=1; this overrides any increment in the same cycle.
REQ-035 SHALL wrap buf_addr from 511 to 0 modulo 512.
REQ-036 SHALL, on the rising edge of img_mounted, set fileno=FILENO, filetype=ioctl_index[7:6], readonly=1, filesize=img_size[31:0], and toggle mounted.
REQ-037 SHALL keep ZPU_IN2 and ZPU_IN3 combinational from the internal registers and buf_q.

Reset
REQ-038 SHALL, while RESET_N=0, immediately force: sd_rd=0, sd_wr=0, buf_wr=0, buf_addr=0, sd_lba=0, io_done=1, mounted=0, fileno=0, filetype=0, readonly=0, filesize=0, all edge registers=0, state=IDLE, timeout counter=0.
REQ-039 SHALL, when reset is asserted mid-transfer, drop the request without waiting for sd_ack; a later sd_ack fall SHALL have no effect.

Configuration
REQ-040 SHALL include the write path only when ZPU_SD_WRITE_EN is defined: the block_wr request, and buf_wr on data_wr with lba_sel=0.
REQ-041 SHALL, when ZPU_SD_WRITE_EN is undefined, hold sd_wr and buf_wr at 0, ignore block_wr, and leave sd_lba loading and the read path unchanged.

Verification
REQ-042 SHALL cover LBA load: lba_sel=1, ZPU_OUT3=32'h0000_1234, data_wr pulse -> sd_lba=32'h1234 two edges later, buf_wr stays 0.
REQ-043 SHALL cover a read request: block_rd rise -> sd_rd=1, io_done=0; sd_ack high for 10 cycles -> sd_rd=0 on the first ack cycle; io_done=1 one edge after the ack falls.
REQ-044 SHALL cover buffer writes: io_wr, then 3 data_wr pulses with bytes AA, BB, CC -> buf_wr at addr 0, 1, 2; buf_addr=3 at the end; with the macro undefined, no buf_wr.
REQ-045 SHALL cover timeout: ACK_TIMEOUT=16, block_rd with no ack -> sd_rd falls and io_done=1 after 16 cycles.
REQ-046 SHALL cover mount: img_size=64'h2000, ioctl_index=8'h40, img_mounted rise -> ZPU_IN2=8'hA2, ZPU_IN3=32'h2000 with lba_sel=1.
REQ-047 SHALL cover collisions: block_rd and block_wr rise in the same cycle -> only sd_rd; RESET_N low during REQ -> sd_rd=0 asynchronously.
